// File: rtl/halfband_mac_scheduler.sv
// Sequencer for a decimate-by-2 halfband FIR: one shared external MAC walks the even taps.
// Define HB_SAT_COUNT_EN to add the sat_count output (count of clamped results).
module halfband_mac_scheduler #(
    parameter int  SAMPLE_WIDTH = 6,
    parameter int  COEF_WIDTH   = 16,
    parameter int  ACC_WIDTH    = 32,
    parameter int  TAPS         = 56,
    parameter int  ADDR_WIDTH   = 7,
    parameter int  OUT_SHIFT    = 16,
    localparam int NUM_MACS     = TAPS / 2,
    localparam int CA_W         = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    output logic                           ready_in,
    input  logic signed [SAMPLE_WIDTH-1:0] data_in,
    output logic        [CA_W-1:0]         coef_addr,
    input  logic signed [COEF_WIDTH-1:0]   coef_data,
    output logic                           mac_en,
    output logic                           mac_clear,
    output logic                           mac_last,
    output logic signed [SAMPLE_WIDTH-1:0] mac_a,
    output logic signed [COEF_WIDTH-1:0]   mac_b,
    input  logic                           mac_acc_valid,
    input  logic signed [ACC_WIDTH-1:0]    mac_acc,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic signed [SAMPLE_WIDTH-1:0] data_out,
    output logic                           busy
`ifdef HB_SAT_COUNT_EN
    ,
    output logic        [15:0]             sat_count
`endif
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                         r_state;
    logic signed [SAMPLE_WIDTH-1:0] r_buf [DEPTH];
    logic        [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic        [ADDR_WIDTH-1:0]   r_rd_addr;
    logic        [FILL_W-1:0]       r_fill;
    logic                           r_phase;
    logic        [CA_W-1:0]         r_j;
    logic                           r_mac_en;
    logic                           r_mac_clear;
    logic                           r_mac_last;
    logic                           r_valid_out;
    logic signed [SAMPLE_WIDTH-1:0] r_data_out;

    logic                           w_accept;
    logic        [FILL_W-1:0]       w_fill_next;
    logic                           w_trigger;
    logic signed [ACC_WIDTH:0]      w_rounded;

    // One extra bit of headroom so adding the half-LSB never wraps.
    function automatic logic signed [ACC_WIDTH:0] round_acc(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] half;
        ext                = {acc[ACC_WIDTH-1], acc};
        half               = '0;
        half[OUT_SHIFT-1]  = 1'b1;
        return (ext + half) >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sample(input logic signed [ACC_WIDTH:0] v);
        if (v > SAT_MAX) return SAT_MAX[SAMPLE_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[SAMPLE_WIDTH-1:0];
        return v[SAMPLE_WIDTH-1:0];
    endfunction

    assign w_accept    = valid_in && (r_state == S_IDLE);
    assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    assign w_trigger   = w_accept && r_phase && (w_fill_next == FILL_FULL);
    assign w_rounded   = round_acc(mac_acc);

    assign ready_in  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign coef_addr = r_j;
    assign mac_en    = r_mac_en;
    assign mac_clear = r_mac_clear;
    assign mac_last  = r_mac_last;
    assign mac_a     = r_buf[r_rd_addr];
    assign mac_b     = coef_data;
    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;

    always_ff @(posedge clk) begin
        if (w_accept && !reset) begin
            r_buf[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_addr   <= '0;
            r_fill      <= '0;
            r_phase     <= 1'b0;
            r_j         <= '0;
            r_mac_en    <= 1'b0;
            r_mac_clear <= 1'b0;
            r_mac_last  <= 1'b0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                r_fill   <= w_fill_next;
                r_phase  <= ~r_phase;
            end
            case (r_state)
                S_IDLE: begin
                    // The newest sample is at the pre-increment write pointer.
                    if (w_trigger) begin
                        r_state     <= S_RUN;
                        r_rd_addr   <= r_wr_ptr;
                        r_j         <= '0;
                        r_mac_en    <= 1'b1;
                        r_mac_clear <= 1'b1;
                        r_mac_last  <= (NUM_MACS == 1);
                    end
                end
                S_RUN: begin
                    r_mac_clear <= 1'b0;
                    if (r_mac_last) begin
                        r_state    <= S_DRAIN;
                        r_mac_en   <= 1'b0;
                        r_mac_last <= 1'b0;
                    end else begin
                        r_j        <= r_j + CA_W'(1);
                        r_rd_addr  <= r_rd_addr - ADDR_WIDTH'(2);
                        r_mac_last <= (r_j == CA_W'(NUM_MACS - 2));
                    end
                end
                S_DRAIN: begin
                    if (mac_acc_valid) begin
                        r_data_out  <= sat_sample(w_rounded);
                        r_valid_out <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ready_out) begin
                        r_valid_out <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HB_SAT_COUNT_EN
    logic [15:0] r_sat_count;
    logic        w_clamped;

    assign w_clamped = (w_rounded > SAT_MAX) || (w_rounded < SAT_MIN);
    assign sat_count = r_sat_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if ((r_state == S_DRAIN) && mac_acc_valid && w_clamped && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end
`endif

endmodule
